// File: rtl/fir_ctrl_pkg.sv
// ============================================================================
// Module      : fir_ctrl_pkg
// Description : Shared state encoding and sizing constants for fir_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_ctrl_pkg;

    localparam int DW        = 8;
    localparam int DEPTH     = 64;
    localparam int TAPS      = 9;
    localparam int FIR_LAT   = 6;
    localparam int FLUSH_LEN = TAPS - 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous reset and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_frame_ctrl.sv
// ============================================================================
// Module      : fir_frame_ctrl
// Description : Buffers a frame, streams it plus a zero flush into the FIR,
//               and tags the FIR output with valid/last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_frame_ctrl #(
    parameter int DW      = fir_ctrl_pkg::DW,
    parameter int DEPTH   = fir_ctrl_pkg::DEPTH,
    parameter int TAPS    = fir_ctrl_pkg::TAPS,
    parameter int FIR_LAT = fir_ctrl_pkg::FIR_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          fir_rst_n,
    output logic [DW-1:0] fir_data_in,
    input  logic [DW-1:0] fir_data_out,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          err_ovf
);

    import fir_ctrl_pkg::*;

    localparam int PCW     = $clog2(DEPTH + 1);
    localparam int FCW     = $clog2(TAPS);
    localparam int FLUSH_N = TAPS - 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PCW-1:0]     r_pop_cnt;
    logic [FCW-1:0]     r_flush_cnt;
    logic [DW-1:0]      r_fir_data_in;
    logic               r_fir_rst_n;
    logic               r_tag_vld;
    logic               r_tag_last;
    logic [FIR_LAT-1:0] r_vld_pipe;
    logic [FIR_LAT-1:0] r_last_pipe;
    logic               r_err_ovf;

    logic               w_push;
    logic               w_pop;
    logic               w_cut;
    logic               w_frame_end;
    logic               w_tag_vld;
    logic               w_tag_last;
    logic [DW-1:0]      w_feed;
    logic [DW-1:0]      w_fifo_data;
    logic               w_full;
    logic               w_empty;
    logic [PCW-1:0]     w_count;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign s_ready     = !rst && (r_state == ST_LOAD) && !w_full;
    assign w_push      = s_valid && s_ready;
    // A transfer that fills the buffer without s_last ends the frame early.
    assign w_cut       = w_push && !s_last && (w_count == PCW'(DEPTH - 1));
    assign w_frame_end = w_push && (s_last || (w_count == PCW'(DEPTH - 1)));
    assign w_pop       = (r_state == ST_STREAM) && !w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_tag_vld   = 1'b0;
        w_tag_last  = 1'b0;
        w_feed      = '0;
        case (r_state)
            ST_LOAD: begin
                if (w_frame_end) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_tag_vld = w_pop;
                w_feed    = w_pop ? w_fifo_data : '0;
                if (w_pop && (r_pop_cnt == PCW'(1))) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_tag_vld = 1'b1;
                if (r_flush_cnt == FCW'(1)) begin
                    w_tag_last  = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_LOAD;
            r_pop_cnt     <= '0;
            r_flush_cnt   <= '0;
            r_fir_data_in <= '0;
            r_fir_rst_n   <= 1'b0;
            r_tag_vld     <= 1'b0;
            r_tag_last    <= 1'b0;
            r_vld_pipe    <= '0;
            r_last_pipe   <= '0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fir_data_in <= w_feed;
            r_fir_rst_n   <= 1'b1;
            r_tag_vld     <= w_tag_vld;
            r_tag_last    <= w_tag_last;
            r_vld_pipe    <= {r_vld_pipe[FIR_LAT-2:0], r_tag_vld};
            r_last_pipe   <= {r_last_pipe[FIR_LAT-2:0], r_tag_last};
            if (w_cut) begin
                r_err_ovf <= 1'b1;
            end
            // The frame-ending push lands this same edge, so the length is count+1.
            if ((r_state == ST_LOAD) && w_frame_end) begin
                r_pop_cnt <= w_count + 1'b1;
            end else if (w_pop) begin
                r_pop_cnt <= r_pop_cnt - 1'b1;
            end
            if ((r_state == ST_STREAM) && (w_state_nxt == ST_FLUSH)) begin
                r_flush_cnt <= FCW'(FLUSH_N);
            end else if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

    assign fir_rst_n   = r_fir_rst_n;
    assign fir_data_in = r_fir_data_in;
    assign m_valid     = r_vld_pipe[FIR_LAT-1];
    assign m_last      = r_last_pipe[FIR_LAT-1];
    assign m_data      = fir_data_out;
    assign busy        = (r_state != ST_LOAD) || r_tag_vld || (|r_vld_pipe);
    assign err_ovf     = r_err_ovf;

endmodule

`default_nettype wire
